// File: rtl/i2c_byte_master.sv
// i2c_byte_master -- byte-level I2C master engine.
//
// Executes START / WRITE / READ / STOP commands and drives the open-drain
// SCL/SDA pads (1 = release, 0 = pull low). Every bus symbol is four
// quarters q0..q3, each lasting CLK_DIV system clocks.
//
// Parameters
//   CLK_DIV    clk cycles per SCL quarter period (>= 2)
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd                    0=START 1=WRITE 2=READ 3=STOP
//   cmd_data, cmd_nack     WRITE byte / READ 9th-bit level
//   rsp_valid              one-cycle pulse when a WRITE/READ completes
//   rsp_data, rsp_ack_n    READ byte / WRITE acknowledge sample
//   busy                   ~cmd_ready
//   scl_out, sda_out       registered pad drives
//   sda_in, scl_in         pad readback
// Build option
//   I2C_CLOCK_STRETCH_EN   honour slave clock stretching in q1 of BIT/STOP
module i2c_byte_master #(
  parameter int CLK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_ack_n,
  output logic       busy,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  input  logic       scl_in
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  state_t        state, state_d;
  logic [1:0]    qtr, qtr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          rd_q, rd_d;
  logic          nack_q, nack_d;
  logic [7:0]    sh;
  logic          scl_d, sda_d;
  logic [2:0]    bidx;
  logic          hold;
  logic          sample;

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low freezes the prescaler while SCL is released.
  assign hold = ((state == S_BIT) || (state == S_STOP)) && (qtr == 2'd1) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;
  // Last clock of q3 of the 9th bit; q3 is never stretched.
  assign rsp_valid = (state == S_BIT) && (qtr == 2'd3) && (bit_cnt == 4'd0) && (cnt == '0);
  // Last clock of q2, where the slave's SDA level is settled.
  assign sample    = (state == S_BIT) && (qtr == 2'd2) && (cnt == '0);

  always_comb begin
    state_d = state;
    qtr_d   = qtr;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    byte_d  = byte_q;
    rd_d    = rd_q;
    nack_d  = nack_q;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d  = LOAD;
          qtr_d  = 2'd0;
          bit_d  = 4'd8;
          byte_d = cmd_data;
          rd_d   = (cmd == 2'd2);
          nack_d = cmd_nack;
          unique case (cmd)
            2'd0:    state_d = S_START;
            2'd3:    state_d = S_STOP;
            default: state_d = S_BIT;
          endcase
        end
      end
      default: begin
        if (!hold) begin
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else begin
            cnt_d = LOAD;
            qtr_d = qtr + 2'd1;
            if (qtr == 2'd3) begin
              if ((state == S_BIT) && (bit_cnt != 4'd0)) bit_d = bit_cnt - 4'd1;
              else                                       state_d = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  // Pad levels are derived from the next state so the registered outputs line
  // up exactly with the quarter they belong to. Idle holds the bus as left,
  // which keeps SCL low between bytes and makes a following START a repeat.
  always_comb begin
    scl_d = scl_out;
    sda_d = sda_out;
    bidx  = 3'(bit_d - 4'd1);
    unique case (state_d)
      S_START: begin
        scl_d = (qtr_d != 2'd3);
        sda_d = (qtr_d < 2'd2);
      end
      S_BIT: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        if (bit_d == 4'd0) sda_d = rd_d ? nack_d : 1'b1;
        else               sda_d = rd_d ? 1'b1   : byte_d[bidx];
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = (qtr_d >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      qtr       <= 2'd0;
      cnt       <= '0;
      bit_cnt   <= 4'd0;
      byte_q    <= 8'h00;
      rd_q      <= 1'b0;
      nack_q    <= 1'b0;
      sh        <= 8'h00;
      rsp_data  <= 8'h00;
      rsp_ack_n <= 1'b1;
      scl_out   <= 1'b1;
      sda_out   <= 1'b1;
    end else begin
      state   <= state_d;
      qtr     <= qtr_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      byte_q  <= byte_d;
      rd_q    <= rd_d;
      nack_q  <= nack_d;
      scl_out <= scl_d;
      sda_out <= sda_d;
      if (sample) begin
        if (bit_cnt != 4'd0) sh <= {sh[6:0], sda_in};
        // Publish the read byte at its last data bit so it is stable by rsp_valid.
        if ((bit_cnt == 4'd1) && rd_q) rsp_data <= {sh[6:0], sda_in};
        if ((bit_cnt == 4'd0) && !rd_q) rsp_ack_n <= sda_in;
      end
    end
  end

endmodule
